// File: rtl/tdm_demux.sv
// Receive side of the 8:1 select-mux TDM link: collects one serial bit per slot
// and presents each complete frame as a parallel word through a valid/ready register.

module tdm_demux_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic i_we,
  input  logic i_d,
  output logic o_q
);
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= 1'b0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module tdm_demux #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_din,
  input  logic             i_din_valid,
  input  logic             i_sof,
  output logic [SEL_W-1:0] o_sel_out,
  output logic [N_CH-1:0]  o_dout,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic             o_frame_err,
  output logic             o_overflow
);
  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_dout;
  logic             r_dout_valid;
  logic             r_frame_err;
  logic             r_overflow;

  logic [N_CH-2:0]  w_shadow;
  logic [SEL_W-1:0] w_wr_slot;
  logic             w_shadow_we;
  logic             w_done;
  logic [N_CH-1:0]  w_word;

  // sof always lands in slot 0, whether it opens a frame or resyncs one
  assign w_wr_slot   = i_sof ? '0 : r_cnt;
  assign w_shadow_we = i_din_valid && (i_sof || (r_state == COLLECT));
  assign w_done      = i_din_valid && !i_sof && (r_state == COLLECT) && (r_cnt == LAST_SLOT);
  assign w_word      = {i_din, w_shadow};

  // The last slot bypasses the shadow and goes straight into the output word
  for (genvar g = 0; g < N_CH - 1; g++) begin : g_slot
    tdm_demux_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_shadow_we && (w_wr_slot == SEL_W'(g))),
      .i_d   (i_din),
      .o_q   (w_shadow[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;

      if (i_din_valid) begin
        case (r_state)
          IDLE: begin
            if (i_sof) begin
              r_cnt   <= SEL_W'(1);
              r_state <= COLLECT;
            end
          end
          COLLECT: begin
            if (i_sof) begin
              r_frame_err <= 1'b1;
              r_cnt       <= SEL_W'(1);
            end else if (r_cnt == LAST_SLOT) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        endcase
      end

      // A full holding register with no taker drops the new word, not the old one
      if (w_done) begin
        if (!r_dout_valid || i_dout_ready) begin
          r_dout       <= w_word;
          r_dout_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_dout_valid && i_dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign o_sel_out    = r_cnt;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: hand-written corner sequences followed by a table of
// frames checked through a scoreboard queue.

module tb_tdm_demux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, sof = 1'b0, dout_ready = 1'b0;
  logic [2:0] sel_out;
  logic [7:0] dout;
  logic       dout_valid, frame_err, overflow;

  int n_tests = 0, n_fail = 0;
  int ferr_cnt = 0, ovf_cnt = 0;
  bit mon_en = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] word;
    int         gap;
    int         junk;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[6];

  tdm_demux #(.N_CH(8), .SEL_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .i_sof        (sof),
    .o_sel_out    (sel_out),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    din       = b;
    sof       = s;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input int gap);
    for (int k = 0; k < 8; k++) begin
      send_bit(w[k], k == 0);
      if (k < 7) repeat (gap) idle_cycle();
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overflow)  ovf_cnt++;
  end

  // Scoreboard consumer: every handshake must match the oldest pushed frame
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (frame_err || overflow) check("tbl_spurious_pulse", {frame_err, overflow}, 0);
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) check("tbl_unexpected_word", dout, 32'hFFFF_FFFF);
        else                check("tbl_word", dout, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0;
    logic [7:0] w4;

    tbl[0] = '{8'hAA, 0, 0, 8'hAA};
    tbl[1] = '{8'h55, 0, 0, 8'h55};
    tbl[2] = '{8'hFF, 1, 2, 8'hFF};
    tbl[3] = '{8'h00, 0, 1, 8'h00};
    tbl[4] = '{8'h3C, 2, 0, 8'h3C};
    tbl[5] = '{8'h81, 0, 3, 8'h81};

    // T1: reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 0);
    check("rst_sel", sel_out, 0);
    check("rst_flags", {frame_err, overflow}, 0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_dout", dout, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // T2: back-to-back bits, latency one cycle, valid drops next cycle
    dout_ready = 1'b1;
    w4 = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      send_bit(w4[k], k == 0);
      check("t2_sel", sel_out, (k + 1) % 8);
      if (k < 7) check("t2_no_valid_yet", dout_valid, 0);
    end
    check("t2_valid", dout_valid, 1);
    check("t2_dout", dout, 8'hAA);
    idle_cycle();
    check("t2_valid_drop", dout_valid, 0);

    // T3: junk before sof, gaps between bits
    send_bit(1'b1, 1'b0); idle_cycle();
    send_bit(1'b0, 1'b0); idle_cycle();
    check("t3_junk_sel", sel_out, 0);
    check("t3_junk_valid", dout_valid, 0);
    for (int k = 0; k < 8; k++) begin
      send_bit(w4[k], k == 0);
      if (k < 7) begin
        idle_cycle();
        check("t3_sel_gap", sel_out, k + 1);
      end
    end
    check("t3_valid", dout_valid, 1);
    check("t3_dout", dout, 8'hAA);
    idle_cycle();

    // T4: sof mid-frame resyncs and raises frame_err once
    f0 = ferr_cnt;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t4_sel_partial", sel_out, 5);
    w4 = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      send_bit(w4[k], k == 0);
      if (k == 0) begin
        check("t4_ferr", frame_err, 1);
        check("t4_sel_resync", sel_out, 1);
      end
      if (k == 1) check("t4_ferr_drop", frame_err, 0);
      if (k == 6) check("t4_no_partial_word", dout_valid, 0);
    end
    check("t4_valid", dout_valid, 1);
    check("t4_dout", dout, 8'h0F);
    idle_cycle();
    check("t4_ferr_count", ferr_cnt - f0, 1);

    // T5: consumer stalls, second frame overflows
    dout_ready = 1'b0;
    o0 = ovf_cnt;
    send_frame(8'hAA, 0);
    check("t5_valid", dout_valid, 1);
    check("t5_dout1", dout, 8'hAA);
    send_frame(8'h55, 0);
    check("t5_ovf", overflow, 1);
    check("t5_dout_held", dout, 8'hAA);
    check("t5_valid_held", dout_valid, 1);
    idle_cycle();
    check("t5_ovf_drop", overflow, 0);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_valid_clr", dout_valid, 0);
    check("t5_dout_keep", dout, 8'hAA);
    check("t5_ovf_count", ovf_cnt - o0, 1);

    // T6: async reset mid-frame with a word pending
    dout_ready = 1'b0;
    send_frame(8'h5A, 0);
    check("t6_pending", dout_valid, 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t6_sel_mid", sel_out, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_sel", sel_out, 0);
    check("t6_async_valid", dout_valid, 0);
    check("t6_async_dout", dout, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b1;
    send_frame(8'hC3, 0);
    check("t6_valid", dout_valid, 1);
    check("t6_dout", dout, 8'hC3);
    idle_cycle();
    idle_cycle();

    // Table-driven frames through the scoreboard
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (tbl[i].junk) send_bit(1'($urandom), 1'b0);
      sb.push_back(tbl[i].exp);
      send_frame(tbl[i].word, tbl[i].gap);
    end
    repeat (3) idle_cycle();
    mon_en = 1'b0;
    check("tbl_sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
